// File: rtl/arb_grant_ctl.sv
// Registered grant controller downstream of priority_arbiter.
// Holds a one-hot grant until release, timeout or preemption.
module arb_grant_ctl #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int MAX_HOLD  = 16,
  parameter int PREEMPT   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 arb_req_i,
  input  logic [$clog2(N)-1:0] arb_sel_i,
  input  logic [PRIO_BITS-1:0] arb_prio_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_sel_o,
  output logic [PRIO_BITS-1:0] gnt_prio_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 preempt_o,
  output logic [N-1:0]         mask_o
);

  localparam int SW = $clog2(N);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST =
    CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t              state, state_d;
  logic [N-1:0]        gnt_d, mask_d;
  logic [SW-1:0]       sel_d;
  logic [PRIO_BITS-1:0] prio_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic                to_d, pe_d;
  logic                rel, tmo, pre;

  always_comb begin
    rel = done_i[gnt_sel_o] | ~req_i[gnt_sel_o];
    tmo = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    pre = (PREEMPT != 0) && arb_req_i &&
          (arb_sel_i != gnt_sel_o) &&
          (arb_prio_i < gnt_prio_o);
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt_o;
    sel_d   = gnt_sel_o;
    prio_d  = gnt_prio_o;
    cnt_d   = cnt;
    mask_d  = mask_o;
    to_d    = 1'b0;
    pe_d    = 1'b0;
    unique case (state)
      IDLE: begin
        mask_d = '0;
        if (arb_req_i) begin
          state_d = GRANT;
          sel_d   = arb_sel_i;
          prio_d  = arb_prio_i;
          gnt_d   = N'(1) << arb_sel_i;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel || tmo || pre) begin
          state_d = RELEASE;
          gnt_d   = '0;
          // release outranks timeout, which outranks preemption
          if (!rel && tmo) begin
            to_d   = 1'b1;
            mask_d = N'(1) << gnt_sel_o;
          end else if (!rel && pre) begin
            pe_d = 1'b1;
          end
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      gnt_o      <= '0;
      gnt_sel_o  <= '0;
      gnt_prio_o <= '0;
      cnt        <= '0;
      mask_o     <= '0;
      timeout_o  <= 1'b0;
      preempt_o  <= 1'b0;
    end else begin
      state      <= state_d;
      gnt_o      <= gnt_d;
      gnt_sel_o  <= sel_d;
      gnt_prio_o <= prio_d;
      cnt        <= cnt_d;
      mask_o     <= mask_d;
      timeout_o  <= to_d;
      preempt_o  <= pe_d;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_arb_grant_ctl.sv
// Bench for arb_grant_ctl: directed scenarios plus random
// traffic checked against an ownership-level reference model.
module tb_arb_grant_ctl;

  localparam int N  = 8;
  localparam int PB = 3;
  localparam int MH = 16;
  localparam int PE = 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          arb_req = 1'b0;
  logic [2:0]    arb_sel = '0;
  logic [PB-1:0] arb_prio = '0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  gnt;
  logic [2:0]    gnt_sel;
  logic [PB-1:0] gnt_prio;
  logic          busy, timeout, preempt;
  logic [N-1:0]  mask;

  int checks = 0;
  int errors = 0;

  arb_grant_ctl #(
    .N(N), .PRIO_BITS(PB), .MAX_HOLD(MH), .PREEMPT(PE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .arb_req_i(arb_req), .arb_sel_i(arb_sel),
    .arb_prio_i(arb_prio), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_sel_o(gnt_sel), .gnt_prio_o(gnt_prio),
    .busy_o(busy), .timeout_o(timeout),
    .preempt_o(preempt), .mask_o(mask)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the grant, for how long, and whether
  // the one-cycle cooldown after a grant is in progress.
  int owner = -1;
  int age = 0;
  bit cooling = 0;
  int m_sel = 0;
  int m_prio = 0;
  bit m_to = 0;
  bit m_pe = 0;
  int m_mask = -1;

  always @(posedge clk or negedge rst_ni) begin : model
    bit drop;
    if (!rst_ni) begin
      owner = -1; age = 0; cooling = 0;
      m_sel = 0; m_prio = 0; m_to = 0; m_pe = 0; m_mask = -1;
    end else begin
      m_to = 0;
      m_pe = 0;
      drop = 0;
      if (cooling) begin
        cooling = 0;
      end else if (owner >= 0) begin
        if (done[owner] || !req[owner]) begin
          drop = 1;
        end else if (MH != 0 && age == MH) begin
          drop = 1; m_to = 1; m_mask = owner;
        end else if (PE != 0 && arb_req && int'(arb_sel) != owner
                     && int'(arb_prio) < m_prio) begin
          drop = 1; m_pe = 1;
        end
        if (drop) begin
          owner = -1; cooling = 1;
        end else begin
          age++;
        end
      end else begin
        m_mask = -1;
        if (arb_req) begin
          owner = int'(arb_sel);
          m_sel = owner;
          m_prio = int'(arb_prio);
          age = 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg, em;
    if (rst_ni) begin
      eg = (owner >= 0) ? (N'(1) << owner) : '0;
      em = (m_mask >= 0) ? (N'(1) << m_mask) : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_sel", 32'(gnt_sel), 32'(m_sel));
      chk("gnt_prio", 32'(gnt_prio), 32'(m_prio));
      chk("busy", 32'(busy), 32'(owner >= 0 || cooling));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("preempt", 32'(preempt), 32'(m_pe));
      chk("mask", 32'(mask), 32'(em));
      chk("onehot", 32'($onehot0(gnt)), 32'd1);
    end
  end

  task automatic offer(bit r, int s, int p);
    arb_req  = r;
    arb_sel  = 3'(s);
    arb_prio = PB'(p);
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mask", 32'(mask), 32'h0);
    chk("rst_pulses", 32'({timeout, preempt}), 32'h0);
    rst_ni = 1'b1;
    req = 8'hFF;
    @(negedge clk);

    // basic grant and release
    offer(1, 5, 3);
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h20);
    chk("t1_prio", 32'(gnt_prio), 32'd3);
    offer(0, 0, 0);
    repeat (3) @(negedge clk);
    done = 8'h20;
    @(negedge clk);
    done = '0;
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'h0);

    // request drop with a stray done on another source
    offer(1, 2, 4);
    @(negedge clk);
    offer(0, 0, 0);
    req = 8'hFB;
    done = 8'h40;
    @(negedge clk);
    req = 8'hFF;
    done = '0;
    chk("t2_gnt", 32'(gnt), 32'h0);
    chk("t2_pulses", 32'({timeout, preempt}), 32'h0);
    @(negedge clk);

    // timeout after exactly MAX_HOLD cycles
    offer(1, 1, 4);
    @(negedge clk);
    offer(0, 0, 0);
    cnt = 0;
    while (gnt != 0 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("t3_len", 32'(cnt), 32'd16);
    chk("t3_to", 32'(timeout), 32'h1);
    chk("t3_mask", 32'(mask), 32'h02);
    offer(1, 4, 1);
    repeat (2) @(negedge clk);
    chk("t3_gnt4", 32'(gnt), 32'h10);
    chk("t3_clr", 32'(mask), 32'h0);
    offer(0, 0, 0);
    done = 8'h10;
    @(negedge clk);
    done = '0;
    @(negedge clk);

    // preemption: equal priority ignored, strictly higher taken
    offer(1, 3, 5);
    @(negedge clk);
    offer(1, 0, 5);
    @(negedge clk);
    chk("t4_nopre", 32'({gnt, preempt}), 32'({8'h08, 1'b0}));
    offer(1, 0, 2);
    @(negedge clk);
    chk("t4_pre", 32'({gnt, preempt}), 32'({8'h00, 1'b1}));
    repeat (2) @(negedge clk);
    chk("t4_gnt0", 32'(gnt), 32'h01);
    chk("t4_prio", 32'(gnt_prio), 32'd2);
    offer(0, 0, 0);
    done = 8'h01;
    @(negedge clk);
    done = '0;
    @(negedge clk);

    // release beats timeout and preemption in the same cycle
    offer(1, 6, 6);
    @(negedge clk);
    offer(0, 0, 0);
    repeat (15) @(negedge clk);
    done = 8'h40;
    offer(1, 0, 0);
    @(negedge clk);
    done = '0;
    offer(0, 0, 0);
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_pulses", 32'({timeout, preempt}), 32'h0);
    chk("t5_mask", 32'(mask), 32'h0);
    @(negedge clk);

    // asynchronous reset mid-grant
    offer(1, 7, 0);
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'h80);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_async", 32'({gnt, gnt_sel, gnt_prio}), 32'h0);
    chk("t6_flags", 32'({busy, timeout, preempt, mask}), 32'h0);
    offer(1, 6, 1);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("t6_regrant", 32'(gnt), 32'h40);
    offer(0, 0, 0);
    done = 8'h40;
    @(negedge clk);
    done = '0;

    // random traffic; second half disables preemption offers
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      req  = ~($urandom & $urandom & $urandom & $urandom);
      done = $urandom & $urandom & $urandom & $urandom & $urandom;
      arb_req = ($urandom_range(0, 3) != 0);
      arb_sel = 3'($urandom);
      arb_prio = (i < 2000) ? PB'($urandom) : PB'(7);
    end
    offer(0, 0, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
